// File: rtl/halflife_ctrl.sv
// Half-life sequencer: loads the down-counter, then strobes one decrement per decay period
// until the counter's registered output reads zero, and then pulses done.
module halflife_ctrl #(
  parameter int N  = 4,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          pause,
  input  logic [N-1:0]  init_val,
  input  logic [PW-1:0] period,
  input  logic [N-1:0]  count_in,
  output logic          cnt_load,
  output logic [N-1:0]  cnt_in,
  output logic          cnt_down,
  output logic          cnt_up,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [PW-1:0] PMIN = PW'(2);

  state_t        state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [PW-1:0] period_r;
  logic [N-1:0]  init_r;
  logic [PW-1:0] period_clamped;
  logic          at_zero;
  logic          last_tick;

  assign period_clamped = (period < PMIN) ? PMIN : period;
  assign at_zero        = (count_in == '0);
  assign last_tick      = (presc == period_r - 1'b1);

  // State register and run-parameter capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      presc    <= '0;
      period_r <= PMIN;
      init_r   <= '0;
    end else begin
      state <= state_nx;
      presc <= presc_nx;
      if (state == IDLE && start) begin
        init_r   <= init_val;
        period_r <= period_clamped;
      end
    end
  end

  // Next-state and prescaler update.
  always_comb begin
    state_nx = state;
    presc_nx = presc;
    unique case (state)
      IDLE: begin
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        presc_nx = '0;
        state_nx = abort ? IDLE : RUN;
      end
      RUN: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (at_zero) begin
          state_nx = DONE;
        end else if (!pause) begin
          presc_nx = last_tick ? '0 : presc + 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Strobes are gated by this cycle's abort/pause/zero so a held counter never sees a stray down.
  always_comb begin
    cnt_load = 1'b0;
    cnt_in   = '0;
    cnt_down = 1'b0;
    cnt_up   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      LOAD: begin
        cnt_load = 1'b1;
        cnt_in   = init_r;
        busy     = 1'b1;
      end
      RUN: begin
        busy = 1'b1;
        if (!abort && !at_zero) begin
          if (pause) cnt_up = 1'b1;
          else       cnt_down = last_tick;
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_halflife_ctrl.sv
// Bench for halflife_ctrl: a behavioural down-counter closes the loop, a scoreboard queue holds
// expected strobes (kind, cycle, value) and a negedge monitor pops and compares them.
module tb_halflife_ctrl;

  localparam int N  = 4;
  localparam int PW = 8;

  localparam logic [1:0] K_LOAD = 2'd0;
  localparam logic [1:0] K_DOWN = 2'd1;
  localparam logic [1:0] K_UP   = 2'd2;
  localparam logic [1:0] K_DONE = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] cyc;
    logic [3:0]  val;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          pause = 1'b0;
  logic [N-1:0]  init_val = '0;
  logic [PW-1:0] period = '0;
  logic [N-1:0]  count_in;
  logic          cnt_load;
  logic [N-1:0]  cnt_in;
  logic          cnt_down;
  logic          cnt_up;
  logic          busy;
  logic          done;

  int unsigned cyc = 0;
  int unsigned c0 = 0;
  int          checks = 0;
  int          failures = 0;
  ev_t         expq[$];
  logic [N-1:0] cnt_model = '0;

  halflife_ctrl #(.N(N), .PW(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .pause    (pause),
    .init_val (init_val),
    .period   (period),
    .count_in (count_in),
    .cnt_load (cnt_load),
    .cnt_in   (cnt_in),
    .cnt_down (cnt_down),
    .cnt_up   (cnt_up),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream half-life counter: load wins, up means hold, down decrements.
  always @(posedge clk) begin
    if (rst)                      cnt_model <= '0;
    else if (cnt_load)            cnt_model <= cnt_in;
    else if (cnt_down && !cnt_up) cnt_model <= cnt_model - 1'b1;
  end
  assign count_in = cnt_model;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input int unsigned off, input logic [3:0] val);
    ev_t e;
    e.kind = kind;
    e.cyc  = c0 + off;
    e.val  = val;
    expq.push_back(e);
  endtask

  task automatic observe(input logic [1:0] kind, input logic [3:0] val);
    ev_t e, a;
    a.kind = kind;
    a.cyc  = cyc;
    a.val  = val;
    checks++;
    if (expq.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event actual kind=%0d cycle=%0d val=%0d required none",
               kind, cyc, val);
    end else begin
      e = expq.pop_front();
      if (a !== e) begin
        failures++;
        $display("FAIL event actual kind=%0d cycle=%0d val=%0d required kind=%0d cycle=%0d val=%0d",
                 a.kind, a.cyc, a.val, e.kind, e.cyc, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (cnt_load) observe(K_LOAD, cnt_in);
    if (cnt_down) observe(K_DOWN, count_in);
    if (cnt_up)   observe(K_UP, 4'd0);
    if (done)     observe(K_DONE, 4'd0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int unsigned off);
    while (cyc < c0 + off) tick(1);
  endtask

  task automatic begin_run(input logic [N-1:0] iv, input logic [PW-1:0] p);
    init_val = iv;
    period   = p;
    start    = 1'b1;
    c0       = cyc;
  endtask

  task automatic drain(input string name);
    chk(name, expq.size(), 0);
    expq.delete();
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {cnt_load, cnt_down, cnt_up, busy, done, 4'(cnt_in)}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset, then start coinciding with reset is swallowed
    tick(2);
    rst = 1'b0;
    tick(1);
    chk_all_zero("reset_outputs");
    rst = 1'b1; start = 1'b1; init_val = 4'd7; period = 8'd3;
    tick(1);
    rst = 1'b0; start = 1'b0;
    tick(1);
    chk("start_under_rst_busy0", busy, 0);
    tick(1);
    chk_all_zero("start_under_rst_idle");

    // 2: init 3, period 4
    begin_run(4'd3, 8'd4);
    push(K_LOAD, 1, 4'd3);
    push(K_DOWN, 5, 4'd3);
    push(K_DOWN, 9, 4'd2);
    push(K_DOWN, 13, 4'd1);
    push(K_DONE, 15, 4'd0);
    tick(1); start = 1'b0;
    chk("t2_busy_c1", busy, 1);
    wait_to(14);
    chk("t2_busy_c14", busy, 1);
    chk("t2_count_c14", count_in, 0);
    wait_to(15);
    chk("t2_busy_c15", busy, 0);
    wait_to(17);
    drain("t2_drain");

    // 3a: init 0 -> done in cycle 3, no decrement
    begin_run(4'd0, 8'd10);
    push(K_LOAD, 1, 4'd0);
    push(K_DONE, 3, 4'd0);
    tick(1); start = 1'b0;
    wait_to(2);
    chk("t3a_busy_c2", busy, 1);
    wait_to(3);
    chk("t3a_busy_c3", busy, 0);
    wait_to(5);
    drain("t3a_drain");

    // 3b: period 0 clamps to 2; start during DONE is ignored
    begin_run(4'd2, 8'd0);
    push(K_LOAD, 1, 4'd2);
    push(K_DOWN, 3, 4'd2);
    push(K_DOWN, 5, 4'd1);
    push(K_DONE, 7, 4'd0);
    tick(1); start = 1'b0;
    wait_to(7);
    start = 1'b1; init_val = 4'd7; period = 8'd3;
    tick(1); start = 1'b0;
    wait_to(10);
    chk("t3b_start_in_done_busy", busy, 0);
    drain("t3b_drain");

    // 4: pause across cycles 4..8 shifts the schedule by 5
    begin_run(4'd5, 8'd3);
    push(K_LOAD, 1, 4'd5);
    for (int unsigned i = 4; i <= 8; i++) push(K_UP, i, 4'd0);
    push(K_DOWN, 9, 4'd5);
    push(K_DOWN, 12, 4'd4);
    push(K_DOWN, 15, 4'd3);
    push(K_DOWN, 18, 4'd2);
    push(K_DOWN, 21, 4'd1);
    push(K_DONE, 23, 4'd0);
    tick(1); start = 1'b0;
    wait_to(4);
    pause = 1'b1;
    wait_to(9);
    pause = 1'b0;
    wait_to(22);
    chk("t4_busy_c22", busy, 1);
    wait_to(25);
    drain("t4_drain");

    // 5: start during RUN ignored, abort in cycle 6
    begin_run(4'd4, 8'd3);
    push(K_LOAD, 1, 4'd4);
    push(K_DOWN, 4, 4'd4);
    tick(1); start = 1'b0;
    wait_to(3);
    start = 1'b1; init_val = 4'd9; period = 8'd2;
    tick(1); start = 1'b0;
    wait_to(6);
    abort = 1'b1;
    tick(1); abort = 1'b0;
    chk("t5_busy_c7", busy, 0);
    wait_to(9);
    chk("t5_count_held", count_in, 3);
    chk("t5_busy_c9", busy, 0);
    drain("t5_drain");

    // 6: reset mid-run, then a clean rerun with fresh values
    begin_run(4'd5, 8'd3);
    push(K_LOAD, 1, 4'd5);
    push(K_DOWN, 4, 4'd5);
    push(K_DOWN, 7, 4'd4);
    tick(1); start = 1'b0;
    wait_to(8);
    rst = 1'b1;
    tick(1); rst = 1'b0;
    chk_all_zero("t6_after_rst");
    drain("t6a_drain");
    begin_run(4'd2, 8'd5);
    push(K_LOAD, 1, 4'd2);
    push(K_DOWN, 6, 4'd2);
    push(K_DOWN, 11, 4'd1);
    push(K_DONE, 13, 4'd0);
    tick(1); start = 1'b0;
    wait_to(15);
    chk("t6_busy_end", busy, 0);
    drain("t6b_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
